// File: rtl/frame_gen_if.sv
// Framed word stream from the test-frame generator toward the serializer/TX path.
// Master drives data/valid/markers; slave returns ready.
interface frame_gen_if #(
  parameter int unsigned DATA_W = 10
) ();
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eof;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eof,
    output out_ready
  );
endinterface

// File: rtl/frame_gen.sv
// Test-frame generator: head word, configurable payload (PRBS, inverted PRBS, counter or fill),
// tail word and optional inter-frame gap, with valid/ready backpressure and registered outputs.
module frame_gen #(
  parameter int unsigned       DATA_W       = 10,
  parameter int unsigned       LEN_W        = 16,
  parameter int unsigned       GAP_W        = 8,
  parameter int unsigned       POLY_LENGTH  = 9,
  parameter int unsigned       POLY_TAP     = 5,
  parameter logic [DATA_W-1:0] HEAD_PATTERN = DATA_W'('h333),
  parameter logic [DATA_W-1:0] TAIL_PATTERN = DATA_W'('h333),
  parameter logic [DATA_W-1:0] IDLE_PATTERN = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_fill,
  input  logic              cfg_reseed,
  frame_gen_if.master       out_if,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {StIdle, StHead, StPayload, StTail, StGap} state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     k_q, k_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [DATA_W-1:0]    fill_q, fill_d;
  logic [POLY_LENGTH-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 busy_q, busy_d;
  logic                 xfer, start, go_idle;

  // Word built from the next DATA_W feedback bits, first bit in the MSB; the LFSR itself is not
  // stepped here so the presented word can be held through stalls.
  function automatic logic [DATA_W-1:0] prbs_word(input logic [POLY_LENGTH-1:0] s);
    logic [POLY_LENGTH-1:0] t;
    logic [DATA_W-1:0]      w;
    logic                   b;
    t = s;
    w = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      b = t[POLY_LENGTH-1] ^ t[POLY_TAP-1];
      w[DATA_W-1-i] = b;
      t = {t[POLY_LENGTH-2:0], b};
    end
    return w;
  endfunction

  function automatic logic [POLY_LENGTH-1:0] lfsr_adv(input logic [POLY_LENGTH-1:0] s);
    logic [POLY_LENGTH-1:0] t;
    t = s;
    for (int i = 0; i < int'(DATA_W); i++) begin
      t = {t[POLY_LENGTH-2:0], t[POLY_LENGTH-1] ^ t[POLY_TAP-1]};
    end
    return t;
  endfunction

  function automatic logic [DATA_W-1:0] payload_word(input logic [POLY_LENGTH-1:0] s,
                                                     input logic [1:0]             mode,
                                                     input logic [LEN_W-1:0]       k,
                                                     input logic [DATA_W-1:0]      fill);
    logic [DATA_W-1:0] w;
    case (mode)
      2'd0:    w = prbs_word(s);
      2'd1:    w = ~prbs_word(s);
      2'd2:    w = DATA_W'(k);
      default: w = fill;
    endcase
    return w;
  endfunction

  assign xfer = valid_q & out_if.out_ready;

  always_comb begin
    lfsr_nxt    = lfsr_adv(lfsr_q);
    state_d     = state_q;
    k_d         = k_q;
    len_d       = len_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    mode_d      = mode_q;
    fill_d      = fill_q;
    lfsr_d      = lfsr_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    start       = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable) start = 1'b1;
      end
      StHead: begin
        if (xfer) begin
          sof_d = 1'b0;
          if (len_q == '0) begin
            state_d = StTail;
            data_d  = TAIL_PATTERN;
            eof_d   = 1'b1;
          end else begin
            state_d = StPayload;
            k_d     = '0;
            data_d  = payload_word(lfsr_q, mode_q, '0, fill_q);
          end
        end
      end
      StPayload: begin
        if (xfer) begin
          lfsr_d = lfsr_nxt;
          if (k_q == len_q - LEN_W'(1)) begin
            state_d = StTail;
            data_d  = TAIL_PATTERN;
            eof_d   = 1'b1;
          end else begin
            k_d    = k_q + LEN_W'(1);
            data_d = payload_word(lfsr_nxt, mode_q, k_q + LEN_W'(1), fill_q);
          end
        end
      end
      StTail: begin
        if (xfer) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (gap_q != '0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
            valid_d   = 1'b0;
            data_d    = IDLE_PATTERN;
            eof_d     = 1'b0;
          end else if (enable) begin
            start = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == gap_q - GAP_W'(1)) begin
          if (enable) start = 1'b1;
          else        go_idle = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Frame start relatches the configuration so mid-frame cfg changes never leak in.
    if (start) begin
      state_d = StHead;
      len_d   = cfg_len;
      gap_d   = cfg_gap;
      mode_d  = cfg_mode;
      fill_d  = cfg_fill;
      k_d     = '0;
      if (cfg_reseed) lfsr_d = '1;
      valid_d = 1'b1;
      data_d  = HEAD_PATTERN;
      sof_d   = 1'b1;
      eof_d   = 1'b0;
    end

    if (go_idle) begin
      state_d = StIdle;
      valid_d = 1'b0;
      data_d  = IDLE_PATTERN;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      mode_q      <= '0;
      fill_q      <= '0;
      lfsr_q      <= '1;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= IDLE_PATTERN;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      mode_q      <= mode_d;
      fill_q      <= fill_d;
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_sof   = sof_q;
  assign out_if.out_eof   = eof_q;
  assign busy             = busy_q;
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_frame_gen.sv
// Directed bench for frame_gen: table of single frames per payload mode, then hand sequences
// for gaps, back-to-back frames, random backpressure and reset mid-frame.
module tb_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_gap;
  logic [1:0]  cfg_mode;
  logic [9:0]  cfg_fill;
  logic        cfg_reseed;
  logic        busy;
  logic [15:0] frame_cnt;

  frame_gen_if #(.DATA_W(10)) bus ();

  frame_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_len   (cfg_len),
    .cfg_gap   (cfg_gap),
    .cfg_mode  (cfg_mode),
    .cfg_fill  (cfg_fill),
    .cfg_reseed(cfg_reseed),
    .out_if    (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0] m_lfsr;

  typedef struct {
    logic [1:0]      mode;
    logic [15:0]     len;
    logic [9:0]      fill;
    logic            reseed;
    int              n;
    logic [6:0][9:0] w;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference PRBS: shift the feedback bits into the word one at a time.
  task automatic m_gen(output logic [9:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      b      = m_lfsr[8] ^ m_lfsr[4];
      m_lfsr = {m_lfsr[7:0], b};
      w      = {w[8:0], b};
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [9:0] p1, p2, p3, p4, p5, p6, tmp;
    logic [9:0] exp_d [15];
    logic       exp_v [15];
    logic [9:0] exp_q [$];
    logic [9:0] got_q [$];
    logic [9:0] pd;
    logic       ps, pe, stalled, done;
    int         bound;

    cfg_len = 16'd3; cfg_gap = 8'd0; cfg_mode = 2'd0; cfg_fill = 10'h0; cfg_reseed = 1'b1;
    do_reset();

    chk("reset valid", 32'(bus.out_valid), 32'd0);
    chk("reset data", 32'(bus.out_data), 32'd0);
    chk("reset sof", 32'(bus.out_sof), 32'd0);
    chk("reset eof", 32'(bus.out_eof), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'd0);

    m_lfsr = '1;
    m_gen(tmp);
    m_gen(p2);
    m_gen(p3);
    tbl[0] = '{mode: 2'd0, len: 16'd3, fill: 10'h0, reseed: 1'b1, n: 5, w: '0};
    tbl[0].w[0] = 10'h333; tbl[0].w[1] = 10'h01E; tbl[0].w[2] = p2; tbl[0].w[3] = p3;
    tbl[0].w[4] = 10'h333;
    tbl[1] = '{mode: 2'd1, len: 16'd3, fill: 10'h0, reseed: 1'b1, n: 5, w: '0};
    tbl[1].w[0] = 10'h333; tbl[1].w[1] = 10'h3E1; tbl[1].w[2] = ~p2; tbl[1].w[3] = ~p3;
    tbl[1].w[4] = 10'h333;
    tbl[2] = '{mode: 2'd2, len: 16'd4, fill: 10'h0, reseed: 1'b1, n: 6, w: '0};
    tbl[2].w[0] = 10'h333; tbl[2].w[1] = 10'h000; tbl[2].w[2] = 10'h001; tbl[2].w[3] = 10'h002;
    tbl[2].w[4] = 10'h003; tbl[2].w[5] = 10'h333;
    tbl[3] = '{mode: 2'd3, len: 16'd2, fill: 10'h2AA, reseed: 1'b1, n: 4, w: '0};
    tbl[3].w[0] = 10'h333; tbl[3].w[1] = 10'h2AA; tbl[3].w[2] = 10'h2AA; tbl[3].w[3] = 10'h333;
    tbl[4] = '{mode: 2'd0, len: 16'd0, fill: 10'h0, reseed: 1'b1, n: 2, w: '0};
    tbl[4].w[0] = 10'h333; tbl[4].w[1] = 10'h333;
    // No reseed: an empty frame must leave the LFSR untouched, so the first word is 0x01E again.
    tbl[5] = '{mode: 2'd0, len: 16'd1, fill: 10'h0, reseed: 1'b0, n: 3, w: '0};
    tbl[5].w[0] = 10'h333; tbl[5].w[1] = 10'h01E; tbl[5].w[2] = 10'h333;

    for (int t = 0; t < 6; t++) begin
      cfg_mode = tbl[t].mode; cfg_len = tbl[t].len; cfg_fill = tbl[t].fill;
      cfg_reseed = tbl[t].reseed; cfg_gap = 8'd0;
      enable = 1'b1;
      step();
      enable = 1'b0;
      for (int i = 0; i < tbl[t].n; i++) begin
        chk($sformatf("t%0d w%0d valid", t, i), 32'(bus.out_valid), 32'd1);
        chk($sformatf("t%0d w%0d data", t, i), 32'(bus.out_data), 32'(tbl[t].w[i]));
        chk($sformatf("t%0d w%0d sof", t, i), 32'(bus.out_sof), 32'(i == 0));
        chk($sformatf("t%0d w%0d eof", t, i), 32'(bus.out_eof), 32'(i == tbl[t].n - 1));
        step();
      end
      chk($sformatf("t%0d idle valid", t), 32'(bus.out_valid), 32'd0);
      chk($sformatf("t%0d idle busy", t), 32'(busy), 32'd0);
      chk($sformatf("t%0d frame_cnt", t), 32'(frame_cnt), 32'(t + 1));
    end

    // Continuous frames with a 3-cycle gap; enable drops and cfg changes during frame 2.
    for (int i = 0; i < 15; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 10'h000;
    end
    exp_v[0] = 1; exp_d[0] = 10'h333; exp_v[1] = 1; exp_d[1] = 10'h000;
    exp_v[2] = 1; exp_d[2] = 10'h001; exp_v[3] = 1; exp_d[3] = 10'h333;
    exp_v[7] = 1; exp_d[7] = 10'h333; exp_v[8] = 1; exp_d[8] = 10'h000;
    exp_v[9] = 1; exp_d[9] = 10'h001; exp_v[10] = 1; exp_d[10] = 10'h333;
    cfg_mode = 2'd2; cfg_len = 16'd2; cfg_gap = 8'd3; cfg_reseed = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("gap c%0d valid", i), 32'(bus.out_valid), 32'(exp_v[i]));
      chk($sformatf("gap c%0d data", i), 32'(bus.out_data), 32'(exp_d[i]));
      chk($sformatf("gap c%0d sof", i), 32'(bus.out_sof), 32'(i == 0 || i == 7));
      chk($sformatf("gap c%0d busy", i), 32'(busy), 32'(i != 14));
      if (i == 7) begin
        enable = 1'b0; cfg_len = 16'd5; cfg_mode = 2'd3; cfg_fill = 10'h155;
      end
    end
    chk("gap frame_cnt", 32'(frame_cnt), 32'd8);

    // Reset pulse in the middle of a payload.
    cfg_mode = 2'd0; cfg_len = 16'd5; cfg_gap = 8'd0; cfg_reseed = 1'b1;
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    chk("pre-rst busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst valid", 32'(bus.out_valid), 32'd0);
    chk("rst data", 32'(bus.out_data), 32'd0);
    chk("rst sof", 32'(bus.out_sof), 32'd0);
    chk("rst eof", 32'(bus.out_eof), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post-rst valid", 32'(bus.out_valid), 32'd0);
    cfg_len = 16'd1; cfg_reseed = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("post-rst head", 32'(bus.out_data), 32'h333);
    step();
    chk("post-rst p0", 32'(bus.out_data), 32'h01E);
    step();
    chk("post-rst tail eof", 32'(bus.out_eof), 32'd1);
    step();
    chk("post-rst frame_cnt", 32'(frame_cnt), 32'd1);

    // Back-to-back frames without reseed: payload continues the sequence.
    do_reset();
    m_lfsr = '1;
    m_gen(p1); m_gen(p2); m_gen(p3); m_gen(p4);
    cfg_mode = 2'd0; cfg_len = 16'd2; cfg_gap = 8'd0; cfg_reseed = 1'b0;
    exp_d[0] = 10'h333; exp_d[1] = p1; exp_d[2] = p2; exp_d[3] = 10'h333;
    exp_d[4] = 10'h333; exp_d[5] = p3; exp_d[6] = p4; exp_d[7] = 10'h333;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("b2b c%0d valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("b2b c%0d data", i), 32'(bus.out_data), 32'(exp_d[i]));
      chk($sformatf("b2b c%0d sof", i), 32'(bus.out_sof), 32'(i == 0 || i == 4));
      chk($sformatf("b2b c%0d eof", i), 32'(bus.out_eof), 32'(i == 3 || i == 7));
      if (i == 4) enable = 1'b0;
    end
    step();
    chk("b2b idle busy", 32'(busy), 32'd0);
    chk("b2b frame_cnt", 32'(frame_cnt), 32'd2);

    // Random backpressure: accepted stream must match the stall-free sequence.
    do_reset();
    m_lfsr = '1;
    m_gen(p1); m_gen(p2); m_gen(p3); m_gen(p4); m_gen(p5); m_gen(p6);
    exp_q = '{10'h333, p1, p2, p3, 10'h333, 10'h333, p4, p5, p6, 10'h333};
    cfg_mode = 2'd0; cfg_len = 16'd3; cfg_gap = 8'd1; cfg_reseed = 1'b0;
    stalled = 1'b0; done = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
    enable = 1'b1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      step();
      if (stalled) begin
        chk("stall valid", 32'(bus.out_valid), 32'd1);
        chk("stall data", 32'(bus.out_data), 32'(pd));
        chk("stall sof", 32'(bus.out_sof), 32'(ps));
        chk("stall eof", 32'(bus.out_eof), 32'(pe));
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      stalled = bus.out_valid && !bus.out_ready;
      pd = bus.out_data; ps = bus.out_sof; pe = bus.out_eof;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        if (got_q.size() == 6) enable = 1'b0;
        if (got_q.size() == 10) done = 1'b1;
      end
    end
    bus.out_ready = 1'b1;
    chk("stall word count", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      chk($sformatf("stall word %0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    bound = 0;
    do begin
      step();
      bound++;
    end while (busy && bound < 20);
    chk("stall end busy", 32'(busy), 32'd0);
    chk("stall frame_cnt", 32'(frame_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_gen.md
# frame_gen

Parametrised test-frame generator for the color-filter link bench. Emits framed words (head pattern, configurable-length payload, tail pattern) with an internal PRBS/counter/fixed payload source, optional inter-frame gap, and valid/ready backpressure toward the serializer/TX path. It is the generalised successor of the fixed 10-bit, fixed-length PRBS frame source: data width, payload length, gap, pattern source and reseeding are all selectable.

## Interface
- DATA_W, 10, word width
- LEN_W, 16, width of payload-length and word counters
- GAP_W, 8, width of inter-frame gap counter
- POLY_LENGTH, 9, LFSR length (polynomial x^POLY_LENGTH + x^POLY_TAP + 1)
- POLY_TAP, 5, LFSR tap; must satisfy 1 <= POLY_TAP < POLY_LENGTH
- HEAD_PATTERN, 'h333, head word
- TAIL_PATTERN, 'h333, tail word
- IDLE_PATTERN, 0, out_data value when no word is valid
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; high requests frames continuously
- cfg_len  in  LEN_W  payload words per frame (0 = head then tail)
- cfg_gap  in  GAP_W  idle cycles between frames (0 = back-to-back)
- cfg_mode  in  2  0 PRBS, 1 inverted PRBS, 2 incrementing counter, 3 constant cfg_fill
- cfg_fill  in  DATA_W  constant payload for mode 3
- cfg_reseed  in  1  1 = reload LFSR to all-ones at every frame start
- out_data  out  DATA_W  frame word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word
- out_sof  out  1  high with head word
- out_eof  out  1  high with tail word
- busy  out  1  high in any state other than IDLE
- frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0

## Operation
- States: IDLE, HEAD, PAYLOAD, TAIL, GAP. State names the word currently presented; all outputs registered.
- Transfer = out_valid & out_ready. HEAD/PAYLOAD/TAIL advance only on transfer; while stalled out_data/sof/eof held stable.
- IDLE: out_valid 0. enable=1 at edge -> HEAD; cfg_* latched on this edge.
- HEAD: out_data=HEAD_PATTERN, sof=1. On transfer -> PAYLOAD word 0, or TAIL if latched len=0.
- PAYLOAD: word k (k=0..len-1). On transfer of k=len-1 -> TAIL, else k+1.
- TAIL: out_data=TAIL_PATTERN, eof=1. On transfer: frame_cnt+1; gap>0 -> GAP; else enable -> HEAD (relatch cfg, no bubble); else IDLE.
- GAP: out_valid 0, counts latched gap cycles independent of out_ready; on last cycle enable -> HEAD (relatch) else IDLE.
- enable deasserted mid-frame: frame completes through TAIL (and GAP), then IDLE. cfg changes mid-frame ignored.
- LFSR step: b = s[POLY_LENGTH-1] ^ s[POLY_TAP-1]; s = {s[POLY_LENGTH-2:0], b}. PRBS word = next DATA_W values of b, first bit in MSB; LFSR advances DATA_W steps per payload word transferred, never otherwise.
- Seed all-ones at reset; also at each HEAD entry when latched cfg_reseed=1, otherwise sequence continues across frames.
- Mode 1 = bitwise inverse of mode 0. Mode 2 word k = k mod 2^DATA_W, restarts at 0 each frame. Mode 3 = latched cfg_fill.

## Timing
- Reset (async assert, sync release): state IDLE, out_valid 0, out_data IDLE_PATTERN, sof/eof/busy 0, frame_cnt 0, LFSR all-ones, counters 0.
- enable high at edge N -> head valid after edge N (latency 1 cycle).
- With out_ready=1: frame occupies len+2 consecutive valid cycles, then exactly gap invalid cycles.
- frame_cnt updates on edge of tail transfer. busy falls on edge entering IDLE.
- Reset mid-frame: immediate return to reset values; no partial tail emitted.

## Test plan
- Defaults, cfg_mode=0, cfg_reseed=1, cfg_len=3, cfg_gap=0, ready=1, enable one cycle: out_data 0x333(sof), 0x01E, next two PRBS9 words, 0x333(eof), then IDLE; frame_cnt=1.
- cfg_mode=1, same setup: first payload 0x3E1; cfg_mode=2, len=4: 0,1,2,3; cfg_mode=3, fill=0x2AA: all payload 0x2AA.
- enable held, len=2, gap=3: repeating head,p,p,tail + 3 invalid cycles; gap=0 gives tail followed directly by head; reseed=0 gives non-repeating payload across frames.
- Random out_ready stalls (50%) in every state: accepted word stream identical to no-stall run; out_data stable while valid & !ready.
- cfg_len=0: head then tail only, LFSR state unchanged; cfg_len changed mid-frame has no effect until next head.
- rst_n pulsed low mid-payload: outputs to reset values asynchronously; next frame after release restarts from 0x01E.
